// File: rtl/alu_4bit.sv
// Registered 4-bit ALU: eight logic/arithmetic operations with zero, carry and overflow flags.
// Result and flags are captured one clock after a valid operand set is presented.
module alu_4bit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [2:0] ALUControl,
    input  logic       in_valid,
    output logic [3:0] ALUResult,
    output logic       out_valid,
    output logic       zero,
    output logic       carry,
    output logic       overflow
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;

    logic       is_sub;
    logic       is_arith;
    logic [3:0] b_eff;
    logic [4:0] chain;
    logic [3:0] sum_bits;
    logic [3:0] and_bits;
    logic [3:0] or_bits;
    logic [3:0] xor_bits;

    logic [3:0] result_next;
    logic       zero_next;
    logic       carry_next;
    logic       overflow_next;

    logic [3:0] result_reg;
    logic       zero_reg;
    logic       carry_reg;
    logic       overflow_reg;
    logic       valid_reg;

    assign is_sub   = (ALUControl == OP_SUB);
    assign is_arith = (ALUControl == OP_ADD) || is_sub;

    // Subtraction reuses the adder as A + ~B + 1; the +1 enters as carry-in.
    assign b_eff    = is_sub ? ~B : B;
    assign chain[0] = is_sub;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign sum_bits[gi]  = A[gi] ^ b_eff[gi] ^ chain[gi];
            assign chain[gi+1]   = (A[gi] & b_eff[gi]) | (A[gi] & chain[gi]) | (b_eff[gi] & chain[gi]);
            assign and_bits[gi]  = A[gi] & B[gi];
            assign or_bits[gi]   = A[gi] | B[gi];
            assign xor_bits[gi]  = A[gi] ^ B[gi];
        end
    endgenerate

    always_comb begin
        result_next = 4'b0000;
        case (ALUControl)
            OP_AND:  result_next = and_bits;
            OP_OR:   result_next = or_bits;
            OP_ADD:  result_next = sum_bits;
            OP_SUB:  result_next = sum_bits;
            OP_XOR:  result_next = xor_bits;
            OP_NOR:  result_next = ~or_bits;
            OP_NAND: result_next = ~and_bits;
            OP_NOT:  result_next = ~A;
            default: result_next = 4'b0000;
        endcase
    end

    always_comb begin
        overflow_next = 1'b0;
        if (ALUControl == OP_ADD) begin
            overflow_next = (A[3] == B[3]) && (sum_bits[3] != A[3]);
        end else if (is_sub) begin
            overflow_next = (A[3] != B[3]) && (sum_bits[3] != A[3]);
        end
    end

    // For SUB the carry-out is the no-borrow indication (A >= B unsigned).
    assign carry_next = is_arith ? chain[4] : 1'b0;
    assign zero_next  = (result_next == 4'b0000);

    always_ff @(posedge clk) begin
        if (reset) begin
            result_reg   <= 4'b0000;
            zero_reg     <= 1'b1;
            carry_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                result_reg   <= result_next;
                zero_reg     <= zero_next;
                carry_reg    <= carry_next;
                overflow_reg <= overflow_next;
            end
        end
    end

    assign ALUResult = result_reg;
    assign zero      = zero_reg;
    assign carry     = carry_reg;
    assign overflow  = overflow_reg;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_alu_4bit.sv
// Scoreboard bench for alu_4bit: driver pushes model results, monitor pops and compares
// on each falling edge; held outputs are checked whenever no result is expected.
module tb_alu_4bit;

    typedef struct packed {
        logic [3:0] res;
        logic       z;
        logic       c;
        logic       v;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] ALUControl;
    logic       in_valid;
    logic [3:0] ALUResult;
    logic       out_valid;
    logic       zero;
    logic       carry;
    logic       overflow;

    int   total;
    int   bad;
    exp_t sb[$];
    exp_t last_exp;
    logic rst_at_edge;
    logic vld_at_edge;
    logic mon_en;

    alu_4bit dut (
        .clk        (clk),
        .reset      (reset),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .in_valid   (in_valid),
        .ALUResult  (ALUResult),
        .out_valid  (out_valid),
        .zero       (zero),
        .carry      (carry),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model from plain integer arithmetic.
    function automatic exp_t model(input int a, input int b, input int op);
        exp_t e;
        int   r;
        int   sa;
        int   sb_i;
        int   s;
        sa   = (a >= 8) ? a - 16 : a;
        sb_i = (b >= 8) ? b - 16 : b;
        e.c  = 1'b0;
        e.v  = 1'b0;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: begin
                r   = (a + b) % 16;
                e.c = ((a + b) > 15);
                s   = sa + sb_i;
                e.v = (s > 7) || (s < -8);
            end
            3: begin
                r   = (a - b + 16) % 16;
                e.c = (a >= b);
                s   = sa - sb_i;
                e.v = (s > 7) || (s < -8);
            end
            4: r = a ^ b;
            5: r = 15 - (a | b);
            6: r = 15 - (a & b);
            default: r = 15 - a;
        endcase
        e.res = r[3:0];
        e.z   = (r == 0);
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp_v, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic [2:0] op);
        reset      = r;
        in_valid   = v;
        A          = a;
        B          = b;
        ALUControl = op;
        if (v && !r) sb.push_back(model(int'(a), int'(b), int'(op)));
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        rst_at_edge <= reset;
        vld_at_edge <= in_valid && !reset;
    end

    // Monitor: decoupled from the driver, works only from the scoreboard queue.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rst_at_edge) begin
                last_exp = '{res: 4'h0, z: 1'b1, c: 1'b0, v: 1'b0};
                chk("rst_valid", int'(out_valid), 0);
                chk("rst_result", int'(ALUResult), 0);
                chk("rst_zero", int'(zero), 1);
                chk("rst_carry", int'(carry), 0);
                chk("rst_ovf", int'(overflow), 0);
                $display("reset  res=%h z=%b c=%b v=%b", ALUResult, zero, carry, overflow);
            end else begin
                chk("out_valid", int'(out_valid), int'(vld_at_edge));
                if (vld_at_edge) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        last_exp = e;
                        $display("op     res=%h z=%b c=%b v=%b exp=%h/%b%b%b", ALUResult, zero,
                                 carry, overflow, e.res, e.z, e.c, e.v);
                    end
                end else begin
                    $display("hold   res=%h z=%b c=%b v=%b", ALUResult, zero, carry, overflow);
                end
                chk("result", int'(ALUResult), int'(last_exp.res));
                chk("zero", int'(zero), int'(last_exp.z));
                chk("carry", int'(carry), int'(last_exp.c));
                chk("overflow", int'(overflow), int'(last_exp.v));
            end
        end
    end

    logic [2:0] logic_ops [5];
    logic [3:0] arith_a   [6];
    logic [3:0] arith_b   [6];
    logic [2:0] arith_op  [6];

    initial begin
        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        logic_ops = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110};
        arith_a   = '{4'b0011, 4'b0100, 4'b1111, 4'b0111, 4'b1000, 4'b0000};
        arith_b   = '{4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        arith_op  = '{3'b010, 3'b011, 3'b010, 3'b010, 3'b011, 3'b011};

        reset = 1'b1; in_valid = 1'b0; A = 4'h0; B = 4'h0; ALUControl = 3'b000;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        cyc(1'b1, 1'b0, 4'h0, 4'h0, 3'b000);

        // Logic ops on 1100/1010, each separated by an idle cycle.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 4'b1100, 4'b1010, logic_ops[i]);
            cyc(1'b0, 1'b0, 4'h0, 4'h0, 3'b000);
        end
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 4'b1100, 4'($urandom_range(0, 15)), 3'b111);

        for (int i = 0; i < 6; i++)
            cyc(1'b0, 1'b1, arith_a[i], arith_b[i], arith_op[i]);

        // Eight back-to-back ops, then three idle cycles with wandering operands.
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'(i));
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'(i));

        // Reset collides with a valid ADD; the op must be discarded.
        cyc(1'b0, 1'b1, 4'b0101, 4'b0110, 3'b010);
        cyc(1'b1, 1'b1, 4'b0011, 4'b0001, 3'b010);
        cyc(1'b0, 1'b1, 4'b0110, 4'b0011, 3'b011);

        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                3'($urandom_range(0, 7)));
        end

        repeat (3) cyc(1'b0, 1'b0, 4'h0, 4'h0, 3'b000);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
